// File: rtl/ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared definitions for the two-port Ram arbiter:
//   - state_e   : controller states (IDLE, STORE, LOAD, DONE)
//   - P_IFETCH  : index of the instruction-fetch requester (port 0)
//   - P_DATA    : index of the data load/store requester (port 1)
//   - cnt_width : width of the read wait-state counter for a given wait count
// -----------------------------------------------------------------------------
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int P_IFETCH = 0;
  localparam int P_DATA   = 1;

  // A single wait state still needs a 1-bit counter, $clog2(1) would give 0.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Request/acknowledge bundle between one requester and the Ram arbiter.
//   req   : access request, held high by the requester until ack
//   we    : 1 = store, 0 = load (sampled at grant)
//   addr  : word address (sampled at grant)
//   wdata : store data (sampled at grant)
//   ack   : one-cycle completion pulse
//   rdata : load result, valid with ack, held until this port's next load
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
);

  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              ack;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// ram_arbiter_rr_arb2
// Two-way round-robin picker, purely combinational.
//   req_i [1:0] : pending requests
//   ptr_i       : favoured port when both request (0 = port 0, 1 = port 1)
//   gnt_o [1:0] : one-hot grant (all zero when nothing requests)
// A lone request is granted regardless of the pointer.
// -----------------------------------------------------------------------------
module ram_arbiter_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Serialises instruction-fetch (port 0) and data load/store (port 1) accesses
// onto a shared single-port Ram with a combinational, slow read path.
//   clk, rst_n  : clock and asynchronous active-low reset
//   port0_if    : instruction-fetch requester (slave side)
//   port1_if    : data requester (slave side)
//   ram_addr    : Ram word address, changes only when a transaction is granted
//   ram_store   : Ram rdEn pin; high for exactly the one STORE cycle
//   ram_wr_en   : Ram wrEn pin, tied low
//   ram_data    : Ram data bus, driven only while ram_store is high
// Loads wait WAIT_CYCLES edges before capturing ram_data so the Ram output
// has settled; every transaction ends with a one-cycle ack on its port.
// -----------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int  DWIDTH      = 32,
  parameter int  ADEPTH      = 256,
  parameter int  WAIT_CYCLES = 5,
  localparam int AWIDTH      = $clog2(ADEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      port0_if,
  ram_arbiter_if.slave      port1_if,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_store,
  output logic              ram_wr_en,
  inout  wire  [DWIDTH-1:0] ram_data
);

  localparam int CWIDTH = cnt_width(WAIT_CYCLES);

  // Requester inputs gathered into port-indexed vectors.
  logic [1:0]             req_in;
  logic [1:0]             we_in;
  logic [1:0][AWIDTH-1:0] addr_in;
  logic [1:0][DWIDTH-1:0] wdata_in;

  assign req_in[P_IFETCH]   = port0_if.req;
  assign req_in[P_DATA]     = port1_if.req;
  assign we_in[P_IFETCH]    = port0_if.we;
  assign we_in[P_DATA]      = port1_if.we;
  assign addr_in[P_IFETCH]  = port0_if.addr;
  assign addr_in[P_DATA]    = port1_if.addr;
  assign wdata_in[P_IFETCH] = port0_if.wdata;
  assign wdata_in[P_DATA]   = port1_if.wdata;

  state_e                 state_q, state_d;
  logic                   ptr_q, ptr_d;       // port favoured on a tie
  logic                   sel_q, sel_d;       // port being served
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [DWIDTH-1:0]      wdata_q, wdata_d;
  logic                   store_q, store_d;
  logic [CWIDTH-1:0]      cnt_q, cnt_d;
  logic [1:0]             ack_q, ack_d;
  logic [1:0][DWIDTH-1:0] rdata_q, rdata_d;

  logic [1:0] gnt;
  logic       gnt_idx;

  ram_arbiter_rr_arb2 u_rr_arb2 (
    .req_i (req_in),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // gnt is one-hot, so bit 1 alone identifies the winner.
  assign gnt_idx = gnt[P_DATA];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_in) state_d = we_in[gnt_idx] ? STORE : LOAD;
      STORE:   state_d = DONE;
      LOAD:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic. Everything leaving the block is
  // registered, so acks are raised on the edge that enters DONE.
  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    store_d = store_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_in) begin
          sel_d   = gnt_idx;
          addr_d  = addr_in[gnt_idx];
          wdata_d = wdata_in[gnt_idx];
          if (we_in[gnt_idx]) begin
            store_d = 1'b1;
          end else begin
            cnt_d = CWIDTH'(WAIT_CYCLES - 1);
          end
        end
      end
      STORE: begin
        // The Ram captures on this exiting edge; release the bus right after.
        store_d      = 1'b0;
        ack_d[sel_q] = 1'b1;
      end
      LOAD: begin
        if (cnt_q == '0) begin
          rdata_d[sel_q] = ram_data;
          ack_d[sel_q]   = 1'b1;
        end else begin
          cnt_d = cnt_q - CWIDTH'(1);
        end
      end
      DONE: begin
        ptr_d = ~sel_q;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign ram_wr_en = 1'b0;

  // Bus is only ours during STORE; the Ram drives it the rest of the time.
  assign ram_data = store_q ? wdata_q : {DWIDTH{1'bz}};

  assign port0_if.ack   = ack_q[P_IFETCH];
  assign port1_if.ack   = ack_q[P_DATA];
  assign port0_if.rdata = rdata_q[P_IFETCH];
  assign port1_if.rdata = rdata_q[P_DATA];

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Drives both requesters of ram_arbiter against a behavioural Ram, keeps an
// abstract memory image as the reference, and checks every ack in a
// separate monitor process that pops per-port expectation queues.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WC = 5;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) if0 ();
  ram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) if1 ();

  wire  [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_store;
  logic          ram_wr_en;

  ram_arbiter #(.DWIDTH(DW), .ADEPTH(256), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port0_if  (if0),
    .port1_if  (if1),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_wr_en (ram_wr_en),
    .ram_data  (ram_data)
  );

  always #5 clk = ~clk;

  // Behavioural Ram: drives the bus whenever the arbiter is not storing,
  // captures store data mid-cycle while ram_store is high.
  logic [DW-1:0] ram_mem [256];
  assign ram_data = ram_store ? {DW{1'bz}} : ram_mem[ram_addr];

  // Reference memory image, updated in completion order.
  logic [DW-1:0] ref_mem [256];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_ack_cyc = -100;
  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   ack_log[$];

  function automatic logic [DW-1:0] preload(input int i);
    if (i == 250) return 32'h6018FFF1;
    return 32'hC0DE0000 ^ 32'(i * 65537);
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return AW'(r);
    if (r == 8) return 8'hA5;
    return 8'd250;
  endfunction

  task automatic check_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    if (p == 0) begin
      if0.req = r; if0.we = we; if0.addr = a; if0.wdata = d;
    end else begin
      if1.req = r; if1.we = we; if1.addr = a; if1.wdata = d;
    end
  endtask

  function automatic bit get_ack(input int p);
    return (p == 0) ? if0.ack : if1.ack;
  endfunction

  // Called at a negedge; returns at the negedge on which ack is seen, req dropped.
  task automatic drive_port(input int p, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int exp_lat, output bit ok);
    txn_t t;
    int   lat;
    t.we = we; t.addr = a; t.wdata = d;
    if (p == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
    set_port(p, 1'b1, we, a, d);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_ack(p)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout port%0d: got no ack, required ack within 100 cycles", p);
    end else if (exp_lat > 0) begin
      check_eq($sformatf("latency_port%0d_we%0d", p, we), 32'(lat), 32'(exp_lat));
    end
    set_port(p, 1'b0, we, a, d);
  endtask

  task automatic port_stream(input int p, input int n, input int gap_max);
    bit ok;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = int'($urandom_range(0, gap_max));
      repeat (gap) @(negedge clk);
      drive_port(p, 1'($urandom_range(0, 1)), pick_addr(), $urandom, -1, ok);
    end
  endtask

  // Cycle counter and Ram capture.
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = preload(i);
      ref_mem[i] = preload(i);
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ram_store) ram_mem[ram_addr] = ram_data;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ram_store) begin
        check_eq("ack_during_store", {31'd0, if0.ack | if1.ack}, 32'd0);
      end
      if (rst_n && (if0.ack || if1.ack)) begin
        int            p;
        txn_t          t;
        bit            have;
        logic [DW-1:0] act;
        check_eq("ack_exclusive", {31'd0, if0.ack & if1.ack}, 32'd0);
        check_eq("ack_spacing_ge3", {31'd0, (cyc - last_ack_cyc) >= 3}, 32'd1);
        check_eq("ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
        last_ack_cyc = cyc;
        p = if0.ack ? 0 : 1;
        ack_log.push_back(p);
        have = 1'b0;
        if (p == 0 && exp_q0.size() > 0) begin t = exp_q0.pop_front(); have = 1'b1; end
        if (p == 1 && exp_q1.size() > 0) begin t = exp_q1.pop_front(); have = 1'b1; end
        if (!have) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack port%0d: got ack, required none outstanding", p);
        end else if (t.we) begin
          ref_mem[t.addr] = t.wdata;
        end else begin
          act = (p == 0) ? if0.rdata : if1.rdata;
          check_eq($sformatf("rdata_port%0d_addr%02h", p, t.addr), act, ref_mem[t.addr]);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_ack0", {31'd0, if0.ack}, 32'd0);
    check_eq("rst_ack1", {31'd0, if1.ack}, 32'd0);
    check_eq("rst_ram_store", {31'd0, ram_store}, 32'd0);
    check_eq("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check_eq("rst_rdata0", if0.rdata, 32'd0);
    check_eq("rst_rdata1", if1.rdata, 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a load abandons it.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 8'h33, '0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("midload_ram_addr", {24'd0, ram_addr}, 32'h33);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_ack0", {31'd0, if0.ack}, 32'd0);
    check_eq("async_rst_ack1", {31'd0, if1.ack}, 32'd0);
    check_eq("async_rst_ram_store", {31'd0, ram_store}, 32'd0);
    check_eq("async_rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load on the data port, exact latencies.
    @(negedge clk);
    drive_port(1, 1'b1, 8'hA5, 32'hDEADBEEF, 2, ok);
    @(negedge clk);
    drive_port(1, 1'b0, 8'hA5, '0, WC + 1, ok);
    check_eq("load_back_rdata1", if1.rdata, 32'hDEADBEEF);

    // Preloaded word on the fetch port; port 1 result must be held.
    @(negedge clk);
    drive_port(0, 1'b0, 8'd250, '0, WC + 1, ok);
    check_eq("preload_rdata0", if0.rdata, 32'h6018FFF1);
    check_eq("rdata1_held", if1.rdata, 32'hDEADBEEF);

    // Simultaneous requests straight out of reset: port 0 wins and reads old data.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_log.delete();
    fork
      begin bit ok0; drive_port(0, 1'b0, 8'h10, '0, -1, ok0); end
      begin bit ok1; drive_port(1, 1'b1, 8'h10, 32'h1, -1, ok1); end
    join
    check_eq("tie_ack_count", 32'(ack_log.size()), 32'd2);
    check_eq("tie_first_port", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd0);
    check_eq("tie_second_port", 32'(ack_log.size() > 1 ? ack_log[1] : -1), 32'd1);
    check_eq("tie_old_value", if0.rdata, preload(16));

    // Both requests held continuously: grants must alternate starting at port 0.
    ack_log.delete();
    fork
      port_stream(0, 3, 0);
      port_stream(1, 3, 0);
    join
    check_eq("alt_ack_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("alt_grant[%0d]", i),
               32'(i < ack_log.size() ? ack_log[i] : -1), 32'(i % 2));
    end

    // Randomised concurrent traffic with random gaps.
    fork
      port_stream(0, 25, 3);
      port_stream(1, 25, 3);
    join
    repeat (2) @(negedge clk);
    check_eq("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check_eq("queue1_drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
